cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL expose: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  in  1  reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL expose: we_i  in  1  CP0 write enable from the writeback stage.
REQ-004 SHALL expose: waddr_i  in  5  CP0 write register number.
REQ-005 SHALL expose: data_i  in  32  CP0 write data.
REQ-006 SHALL expose: raddr_i  in  5  CP0 read register number (mfc0).
REQ-007 SHALL expose: int_i  in  6  external hardware interrupt lines.
REQ-008 SHALL expose: excepttype_i  in  32  committed exception code; 0 = none.
REQ-009 SHALL expose: current_inst_addr_i  in  32  PC of the excepting instruction.
REQ-010 SHALL expose: is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
REQ-011 SHALL expose: data_o  in/out: out  32  read data for raddr_i.
REQ-012 SHALL expose: count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents.
REQ-013 SHALL expose: timer_int_o  out  1  timer interrupt request.
REQ-014 SHALL use register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PrId 15, Config 16.

Function
REQ-015 data_o SHALL be combinational from registered state; unknown raddr_i returns 0; no write bypass (forwarding is upstream).
REQ-016 Count SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-017 A Count write SHALL load data_i and suppress that cycle's increment.
REQ-018 When Compare != 0 and Count == Compare, timer_int_o SHALL set on the next edge and stay set until Compare is written.
REQ-019 A Compare write SHALL load data_i and clear timer_int_o in the same edge; set and clear together: clear wins.
REQ-020 Status write SHALL load all 32 bits; EPC write SHALL load all 32 bits.
REQ-021 Cause write SHALL update only IP[1:0] (bits 9:8), WP (22), IV (23); other bits unchanged.
REQ-022 Cause IP[7:2] (bits 15:10) SHALL sample int_i every cycle.
REQ-023 Writes to PrId, Config, or unlisted addresses SHALL be ignored.
REQ-024 Exception codes: 0x1 interrupt -> ExcCode 0x00; 0x8 syscall -> 0x08; 0xa invalid instr -> 0x0a; 0xd trap -> 0x0d; 0xc overflow -> 0x0c; 0xe eret.
REQ-025 Non-eret exception with Status.EXL=0: EPC <= current_inst_addr_i - 4 and Cause.BD <= 1 if is_in_delayslot_i, else EPC <= current_inst_addr_i and BD <= 0.
REQ-026 Non-eret exception with Status.EXL=1: EPC and BD SHALL be unchanged.
REQ-027 Every non-eret exception SHALL set Status.EXL=1 and Cause.ExcCode (bits 6:2).
REQ-028 eret SHALL clear Status.EXL; other fields unchanged.
REQ-029 Unlisted nonzero excepttype_i SHALL be ignored.
REQ-030 Exception and write to the same field in one cycle: exception update SHALL win; non-conflicting fields of the write SHALL apply.

Reset
REQ-031 On rst: Count 0, Compare 0, Status 0x10000000, Cause 0, EPC 0, timer_int_o 0.
REQ-032 PrId SHALL be constant 0x004C0102 and Config constant 0x00008000 regardless of reset.
REQ-033 rst SHALL override writes, exceptions, and Count increment in the same cycle.

Structure
REQ-034 Register numbers, exception codes, and reset constants SHALL live in the shared defines package.
REQ-035 Single module; no sub-modules required.

Verification
REQ-036 Reset then idle 5 cycles -> count_o=5, status_o=0x10000000, prid_o=0x004C0102, timer_int_o=0.
REQ-037 Write Compare=20 -> timer_int_o rises the cycle after count_o==20; write Compare=0 -> timer_int_o=0 next cycle.
REQ-038 Write Cause=0xFFFFFFFF with int_i=0 -> cause_o=0x00C00300; int_i=6'b000001 -> cause_o[10]=1 next cycle.
REQ-039 excepttype_i=0x8, addr=0x100, delayslot=1, EXL=0 -> epc_o=0xFC, cause_o[31]=1, ExcCode=8, status_o[1]=1; repeat with addr=0x200 -> epc_o stays 0xFC.
REQ-040 excepttype_i=0xe with EXL=1 -> status_o[1]=0, epc_o unchanged.
REQ-041 Count write 0xFFFFFFFF -> count_o=0xFFFFFFFF then 0x00000000 next cycle; rst asserted with we_i=1 -> reset values win.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and reset/constant values.
package cp0_regfile_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;
   localparam logic [4:0] CP0_CONFIG  = 5'd16;

   localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
   localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
   localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

   localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
   localparam logic [31:0] PRID_VAL    = 32'h004C_0102;
   localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
   // Software-writable Cause bits: IV, WP, IP[1:0]
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   typedef struct packed {
      logic       valid;
      logic       eret;
      logic [4:0] code;
   } exc_t;

   function automatic exc_t decode_exc(input logic [31:0] et);
      exc_t e;
      e = '{valid: 1'b1, eret: 1'b0, code: 5'h00};
      case (et)
         EXC_INTERRUPT: e.code = 5'h00;
         EXC_SYSCALL:   e.code = 5'h08;
         EXC_INST_INV:  e.code = 5'h0a;
         EXC_OVERFLOW:  e.code = 5'h0c;
         EXC_TRAP:      e.code = 5'h0d;
         EXC_ERET:      e.eret = 1'b1;
         default:       e.valid = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: Count/Compare timer, Status, Cause, EPC, constant PrId/Config,
// with exception entry/eret bookkeeping committed from writeback.
module cp0_regfile
   import cp0_regfile_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic        timer_q, timer_d;
   exc_t        exc;

   always_comb begin
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      status_d  = status_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      timer_d   = timer_q | ((compare_q != 32'd0) && (count_q == compare_q));
      exc       = decode_exc(excepttype_i);

      if (we_i) begin
         case (waddr_i)
            CP0_COUNT:   count_d = data_i;
            CP0_COMPARE: begin
               compare_d = data_i;
               timer_d   = 1'b0;
            end
            CP0_STATUS:  status_d = data_i;
            CP0_CAUSE:   cause_d  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
            CP0_EPC:     epc_d    = data_i;
            default:     ;
         endcase
      end

      cause_d[15:10] = int_i;

      // Exception updates come last so they override any same-cycle software write.
      if (exc.valid) begin
         if (exc.eret) begin
            status_d[1] = 1'b0;
         end else begin
            if (!status_q[1]) begin
               epc_d      = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
               cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc.code;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         status_q  <= STATUS_RST;
         cause_q   <= 32'd0;
         epc_q     <= 32'd0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         timer_q   <= timer_d;
      end
   end

   always_comb begin
      case (raddr_i)
         CP0_COUNT:   data_o = count_q;
         CP0_COMPARE: data_o = compare_q;
         CP0_STATUS:  data_o = status_q;
         CP0_CAUSE:   data_o = cause_q;
         CP0_EPC:     data_o = epc_q;
         CP0_PRID:    data_o = PRID_VAL;
         CP0_CONFIG:  data_o = CONFIG_VAL;
         default:     data_o = 32'd0;
      endcase
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign config_o    = CONFIG_VAL;
   assign prid_o      = PRID_VAL;
   assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized scoreboard bench for cp0_regfile: a behavioural model predicts the register
// state after each edge; a monitor compares DUT outputs against the queued predictions.
module tb_cp0_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we_i = 1'b0;
   logic [4:0]  waddr_i = '0;
   logic [31:0] data_i = '0;
   logic [4:0]  raddr_i = '0;
   logic [5:0]  int_i = '0;
   logic [31:0] excepttype_i = '0;
   logic [31:0] current_inst_addr_i = '0;
   logic        is_in_delayslot_i = 1'b0;
   logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   cp0_regfile dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
      .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
      .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
      .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
      .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
      .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] count, compare, status, cause, epc, data;
      logic        timer;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // Model state (architectural registers after the most recent predicted edge)
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
   logic        m_timer;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] ra);
      case (ra)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return 32'h004C0102;
         5'd16:   return 32'h00008000;
         default: return 32'h0;
      endcase
   endfunction

   // Apply one clock's worth of architectural rules to the model.
   task automatic model_edge(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] d,
                             input logic [5:0] irq, input logic [31:0] et, input logic [31:0] pc,
                             input bit ds);
      logic [31:0] cnt, cmp, st, ca, ep;
      logic        tm;
      int          code;
      if (r) begin
         m_count = 0; m_compare = 0; m_status = 32'h10000000; m_cause = 0; m_epc = 0; m_timer = 0;
         return;
      end
      cnt = m_count + 1; cmp = m_compare; st = m_status; ca = m_cause; ep = m_epc;
      tm  = m_timer || (m_compare != 0 && m_count == m_compare);
      if (we) begin
         if (wa == 9)  cnt = d;
         if (wa == 11) begin cmp = d; tm = 0; end
         if (wa == 12) st = d;
         if (wa == 14) ep = d;
         if (wa == 13) begin
            ca[9:8] = d[9:8]; ca[22] = d[22]; ca[23] = d[23];
         end
      end
      ca[15:10] = irq;
      code = -1;
      if (et == 32'h1) code = 0;
      if (et == 32'h8) code = 8;
      if (et == 32'ha) code = 10;
      if (et == 32'hc) code = 12;
      if (et == 32'hd) code = 13;
      if (et == 32'he) st[1] = 0;
      if (code >= 0) begin
         if (m_status[1] == 0) begin
            ep = ds ? pc - 4 : pc;
            ca[31] = ds;
         end
         st[1] = 1;
         ca[6:2] = code[4:0];
      end
      m_count = cnt; m_compare = cmp; m_status = st; m_cause = ca; m_epc = ep; m_timer = tm;
   endtask

   task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] d,
                       input logic [4:0] ra, input logic [5:0] irq, input logic [31:0] et,
                       input logic [31:0] pc, input bit ds);
      exp_t e;
      rst = r; we_i = we; waddr_i = wa; data_i = d; raddr_i = ra; int_i = irq;
      excepttype_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds;
      model_edge(r, we, wa, d, irq, et, pc, ds);
      e.count = m_count; e.compare = m_compare; e.status = m_status; e.cause = m_cause;
      e.epc = m_epc; e.timer = m_timer; e.data = m_read(ra);
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 5'd0, 32'd0, 5'($urandom_range(8, 17)), 6'd0, 32'd0, 32'd0, 0);
   endtask

   // Monitor: outputs are presented every cycle; compare once per edge against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("count", count_o, e.count);
            chk("compare", compare_o, e.compare);
            chk("status", status_o, e.status);
            chk("cause", cause_o, e.cause);
            chk("epc", epc_o, e.epc);
            chk("timer_int", {31'd0, timer_int_o}, {31'd0, e.timer});
            chk("data_o", data_o, e.data);
            chk("prid", prid_o, 32'h004C0102);
            chk("config", config_o, 32'h00008000);
         end
      end
   end

   initial begin
      int n;
      logic [4:0]  wa;
      logic [31:0] d, et;
      logic [4:0]  wlist [10];
      wlist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd31, 5'd3};

      // Reset, then 5 idle cycles
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(5);
      chk("d_count5", count_o, 32'd5);
      chk("d_status_rst", status_o, 32'h10000000);
      chk("d_prid", prid_o, 32'h004C0102);
      chk("d_timer_rst", {31'd0, timer_int_o}, 32'd0);

      // Timer: Compare=20, interrupt the cycle after count hits 20, cleared by Compare=0
      step(0, 1, 5'd11, 32'd20, 5'd11, 0, 0, 0, 0);
      n = 0;
      while (count_o != 32'd20 && n < 100) begin idle(1); n++; end
      chk("d_count_reach20", count_o, 32'd20);
      chk("d_timer_before", {31'd0, timer_int_o}, 32'd0);
      idle(1);
      chk("d_timer_set", {31'd0, timer_int_o}, 32'd1);
      idle(3);
      chk("d_timer_held", {31'd0, timer_int_o}, 32'd1);
      step(0, 1, 5'd11, 32'd0, 5'd11, 0, 0, 0, 0);
      chk("d_timer_clr", {31'd0, timer_int_o}, 32'd0);

      // Cause write mask and interrupt sampling
      step(0, 1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'd0, 0, 0, 0);
      chk("d_cause_mask", cause_o, 32'h00C00300);
      step(0, 0, 0, 0, 5'd13, 6'b000001, 0, 0, 0);
      chk("d_cause_ip2", {31'd0, cause_o[10]}, 32'd1);

      // Syscall in delay slot, then nested exception leaves EPC alone
      step(0, 0, 0, 0, 5'd14, 0, 32'h8, 32'h100, 1);
      chk("d_epc_ds", epc_o, 32'hFC);
      chk("d_bd", {31'd0, cause_o[31]}, 32'd1);
      chk("d_exccode", {27'd0, cause_o[6:2]}, 32'd8);
      chk("d_exl_set", {31'd0, status_o[1]}, 32'd1);
      step(0, 0, 0, 0, 5'd14, 0, 32'h8, 32'h200, 0);
      chk("d_epc_nested", epc_o, 32'hFC);
      step(0, 0, 0, 0, 5'd12, 0, 32'he, 32'h300, 0);
      chk("d_eret_exl", {31'd0, status_o[1]}, 32'd0);
      chk("d_eret_epc", epc_o, 32'hFC);

      // Count wrap and reset priority
      step(0, 1, 5'd9, 32'hFFFFFFFF, 5'd9, 0, 0, 0, 0);
      chk("d_count_max", count_o, 32'hFFFFFFFF);
      idle(1);
      chk("d_count_wrap", count_o, 32'd0);
      step(1, 1, 5'd9, 32'h1234, 5'd9, 0, 32'h8, 32'h40, 0);
      chk("d_rst_count", count_o, 32'd0);
      chk("d_rst_status", status_o, 32'h10000000);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         wa = wlist[$urandom_range(0, 9)];
         d  = $urandom;
         if (wa == 5'd11 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 4));
         case ($urandom_range(0, 15))
            9:       et = 32'h1;
            10:      et = 32'h8;
            11:      et = 32'ha;
            12:      et = 32'hc;
            13:      et = 32'hd;
            14:      et = 32'he;
            15:      et = $urandom;
            default: et = 32'h0;
         endcase
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, wa, d,
              5'($urandom_range(0, 31)), 6'($urandom), et, $urandom, 1'($urandom));
      end
      idle(2);

      n = 0;
      while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
      chk("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
